nios2_debug_cmd_sequencer: RTL and testbench
============================================

# nios2_debug_cmd_sequencer

Sequences host debug commands onto the Nios II CPU debug-slave action interface. Software and test hosts can therefore read and write OCI memory and halt or resume the CPU through a simple valid/ready command port, instead of driving JTAG scans. It sits beside the debug-slave wrapper in the `Chenillard_sys` CPU subsystem. It drives `jdo` and the `take_action_*` strobes, and watches `monitor_ready`, `monitor_error`, `debugack` and `MonDReg`.

## Interface
- `TIMEOUT`, default 1024: maximum cycles spent in any wait state before an error is reported; legal range 2..65535.
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 READ, 01 WRITE, 10 BREAK, 11 RESUME.
- `cmd_addr` in 9: OCI word address.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: response accepted.
- `rsp_data` out 32: read data, or 0 for other ops.
- `rsp_err` out 2: 00 ok, 01 monitor_error, 10 timeout, 11 CPU not halted.
- `jdo` out 38: action payload to the debug slave.
- `take_action_ocimem_a` out 1: address/op strobe.
- `take_action_ocimem_b` out 1: write-data strobe.
- `take_action_break_a` out 1: halt request strobe.
- `take_action_break_b` out 1: resume request strobe.
- `MonDReg` in 32: monitor data register.
- `monitor_ready` in 1: OCI access complete.
- `monitor_error` in 1: OCI access failed.
- `debugack` in 1: CPU is halted in debug mode.

## Operation
- **Output timing.** All outputs are registered Moore outputs decoded from state. Each strobe is high for exactly one cycle.
- **States.** IDLE, ADDR, DATA, WAIT_MON, BRK, RES, WAIT_ACK, RESP.
- **IDLE.**
  - `cmd_ready`=1.
  - On `cmd_valid`, `cmd_op`, `cmd_addr` and `cmd_wdata` are latched.
  - READ/WRITE with `debugack`=0 go directly to RESP with `rsp_err`=11 and `rsp_data`=0.
  - Otherwise READ/WRITE go to ADDR, BREAK goes to BRK, RESUME goes to RES.
- **ADDR.**
  - `take_action_ocimem_a`=1.
  - `jdo`={3'b0, read_flag, 25'b0, addr[8:0]}, where read_flag is `jdo[34]` (1 for READ).
  - Next state: WRITE goes to DATA; READ goes to WAIT_MON.
- **DATA.** `take_action_ocimem_b`=1, `jdo`={6'b0, wdata}. Next state: WAIT_MON.
- **WAIT_MON.**
  - The first cycle ignores the monitor inputs (settle guard).
  - From the second cycle on: `monitor_error` goes to RESP with err 01; else `monitor_ready` goes to RESP with err 00. On a READ, `rsp_data` is captured from `MonDReg` on that edge.
  - Error takes priority over ready when both are high.
- **BRK / RES.**
  - One strobe cycle: `take_action_break_a` in BRK, `take_action_break_b` in RES, with `jdo`=0.
  - Next state: WAIT_ACK.
- **WAIT_ACK.** Exits to RESP with err 00 when `debugack`=1 (BREAK) or `debugack`=0 (RESUME).
- **Timeout.**
  - A wait counter clears on entry to each wait state and increments every wait cycle.
  - Reaching `TIMEOUT` cycles without the exit condition goes to RESP with err 10.
  - If the exit condition and the timeout occur on the same cycle, the exit condition wins.
  - Counter width is clog2(`TIMEOUT`+1) bits; it saturates and never wraps.
- **RESP.** `rsp_valid`=1 with data and err stable. Go to IDLE on `rsp_ready`.
- **Ordering.** Exactly one command is in flight at a time; commands are never reordered or dropped.
- **Non-strobe jdo.** `jdo` holds 0 in every cycle without a strobe.

## Timing
- **Reset values.** State IDLE; `cmd_ready`=1; `rsp_valid`=0; `rsp_data`=0; `rsp_err`=00; `jdo`=0; all strobes 0; wait counter 0.
- **Reset mid-operation.** Reset aborts any state, including a pending response, with no strobe emitted on the reset edge.
- **READ latency.** Counted from the acceptance edge E0 with `monitor_ready` already high:
  - ADDR strobe in cycle E0+1.
  - WAIT_MON in cycles E0+2 (guard) and E0+3.
  - `rsp_valid` from E0+4.
- **WRITE latency.** One cycle longer than READ: `rsp_valid` from E0+5.
- **BREAK latency.** With `debugack` rising one cycle after the strobe: strobe at E0+1, `rsp_valid` at E0+4.
- **Not-halted READ/WRITE.** `rsp_valid` at E0+1 with no strobe.
- **Back-to-back commands.** The earliest next acceptance is the cycle after `rsp_valid`&&`rsp_ready`, because `cmd_ready` rises on return to IDLE.
- **Timeout latency.** `rsp_valid` appears `TIMEOUT` cycles after wait-state entry plus 1.
- **Input stability.** `cmd_*` inputs may change after acceptance without effect.

## Test plan
- **Reset.** Assert `reset` for 2 cycles mid-WAIT_MON → all outputs at their reset values and `cmd_ready`=1 on the next cycle.
- **READ.** `debugack`=1, READ addr 0x0A5, `monitor_ready`=1, `MonDReg`=0xDEADBEEF → one ADDR strobe with `jdo`=0x04_000000A5 (`jdo[34]`=1, address 0x0A5) at E0+1, then `rsp_data`=0xDEADBEEF, err 00 at E0+4.
- **WRITE.** WRITE addr 0x1FF, data 0x12345678 → ADDR strobe with `jdo[34]`=0, then DATA strobe with `jdo[31:0]`=0x12345678 at E0+2, then `rsp_valid` at E0+5.
- **Errors.**
  - READ with `debugack`=0 → err 11 at E0+1, no strobes.
  - `monitor_error` and `monitor_ready` both high → err 01.
- **Timeout.** `TIMEOUT`=8, BREAK with `debugack` held 0 → err 10 exactly 9 cycles after WAIT_ACK entry; ack on cycle 8 → err 00.
- **Back-pressure.** Hold `rsp_ready`=0 for 20 cycles → `rsp_valid`, `rsp_data` and `rsp_err` stable and `cmd_ready`=0 throughout; next command accepted one cycle after release.

Source files
------------

// File: rtl/nios2_debug_cmd_sequencer.sv
// Purpose: turns valid/ready host debug commands into Nios II debug-slave action strobes and a response.
// Latency: READ rsp at E0+4, WRITE at E0+5, BREAK/RESUME at ack+1, not-halted READ/WRITE at E0+1.
// Backpressure: cmd_ready only in IDLE; the response is held stable in RESP until rsp_ready.
module nios2_debug_cmd_sequencer #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [8:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_err,
   output logic [37:0] jdo,
   output logic        take_action_ocimem_a,
   output logic        take_action_ocimem_b,
   output logic        take_action_break_a,
   output logic        take_action_break_b,
   input  logic [31:0] MonDReg,
   input  logic        monitor_ready,
   input  logic        monitor_error,
   input  logic        debugack
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR     = 3'd1;
   localparam logic [2:0] S_DATA     = 3'd2;
   localparam logic [2:0] S_WAIT_MON = 3'd3;
   localparam logic [2:0] S_BRK      = 3'd4;
   localparam logic [2:0] S_RES      = 3'd5;
   localparam logic [2:0] S_WAIT_ACK = 3'd6;
   localparam logic [2:0] S_RESP     = 3'd7;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_BREAK  = 2'b10;

   localparam logic [1:0] ERR_OK          = 2'b00;
   localparam logic [1:0] ERR_MON         = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT     = 2'b10;
   localparam logic [1:0] ERR_NOT_HALTED  = 2'b11;

   logic [2:0]    state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [8:0]    addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic [1:0]    rsp_err_q, rsp_err_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [37:0]   jdo_q, jdo_d;
   logic          ocimem_a_q, ocimem_a_d;
   logic          ocimem_b_q, ocimem_b_d;
   logic          break_a_q, break_a_d;
   logic          break_b_q, break_b_d;
   logic          timed_out;
   logic          ack_ok;

   // Next-state, command latch and response capture.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      timed_out  = (cnt_q >= TO_LIMIT);
      ack_ok     = (op_q == OP_BREAK) ? debugack : !debugack;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d       = cmd_op;
               addr_d     = cmd_addr;
               wdata_d    = cmd_wdata;
               rsp_data_d = '0;
               rsp_err_d  = ERR_OK;
               if (cmd_op == OP_READ || cmd_op == OP_WRITE) begin
                  if (!debugack) begin
                     // OCI memory is only reachable while the CPU sits in debug mode.
                     state_d   = S_RESP;
                     rsp_err_d = ERR_NOT_HALTED;
                  end else begin
                     state_d = S_ADDR;
                  end
               end else if (cmd_op == OP_BREAK) begin
                  state_d = S_BRK;
               end else begin
                  state_d = S_RES;
               end
            end
         end
         S_ADDR: state_d = (op_q == OP_WRITE) ? S_DATA : S_WAIT_MON;
         S_DATA: state_d = S_WAIT_MON;
         S_WAIT_MON: begin
            // First cycle (count 0) is a settle guard: monitor flags may still be stale.
            if (cnt_q != '0) begin
               if (monitor_error || monitor_ready) begin
                  state_d   = S_RESP;
                  rsp_err_d = monitor_error ? ERR_MON : ERR_OK;
                  if (op_q == OP_READ) rsp_data_d = MonDReg;
               end else if (timed_out) begin
                  state_d   = S_RESP;
                  rsp_err_d = ERR_TIMEOUT;
               end
            end
         end
         S_BRK: state_d = S_WAIT_ACK;
         S_RES: state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (ack_ok) begin
               state_d   = S_RESP;
               rsp_err_d = ERR_OK;
            end else if (timed_out) begin
               state_d   = S_RESP;
               rsp_err_d = ERR_TIMEOUT;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d    = S_IDLE;
               rsp_data_d = '0;
               rsp_err_d  = ERR_OK;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Wait counter: zero on entry to a wait state, saturating count while staying there.
   always_comb begin
      cnt_d = '0;
      if ((state_q == S_WAIT_MON || state_q == S_WAIT_ACK) && state_d == state_q) begin
         cnt_d = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + CW'(1);
      end
   end

   // Moore outputs decoded from the next state so they are registered yet aligned with the state.
   always_comb begin
      cmd_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
      ocimem_a_d  = (state_d == S_ADDR);
      ocimem_b_d  = (state_d == S_DATA);
      break_a_d   = (state_d == S_BRK);
      break_b_d   = (state_d == S_RES);
      jdo_d       = '0;
      if (state_d == S_ADDR) begin
         jdo_d = {3'b000, (op_d == OP_READ), 25'd0, addr_d};
      end else if (state_d == S_DATA) begin
         jdo_d = {6'd0, wdata_d};
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_READ;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= ERR_OK;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         jdo_q       <= '0;
         ocimem_a_q  <= 1'b0;
         ocimem_b_q  <= 1'b0;
         break_a_q   <= 1'b0;
         break_b_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         jdo_q       <= jdo_d;
         ocimem_a_q  <= ocimem_a_d;
         ocimem_b_q  <= ocimem_b_d;
         break_a_q   <= break_a_d;
         break_b_q   <= break_b_d;
      end
   end

   assign cmd_ready            = cmd_ready_q;
   assign rsp_valid            = rsp_valid_q;
   assign rsp_data             = rsp_data_q;
   assign rsp_err              = rsp_err_q;
   assign jdo                  = jdo_q;
   assign take_action_ocimem_a = ocimem_a_q;
   assign take_action_ocimem_b = ocimem_b_q;
   assign take_action_break_a  = break_a_q;
   assign take_action_break_b  = break_b_q;

endmodule

// File: tb/tb_nios2_debug_cmd_sequencer.sv
// Bench for nios2_debug_cmd_sequencer: command-level timeline model, per-cycle compare, directed and random commands.
// Each command's response cycle and content are derived from its wait-event index, then replayed cycle by cycle.
// Response back-pressure is randomized; a long 20-cycle stall is exercised explicitly.
`timescale 1ns/1ps
module tb_nios2_debug_cmd_sequencer;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [8:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_err;
   logic [37:0] jdo;
   logic        ta_a, ta_b, ta_ba, ta_bb;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;
   logic        debugack;

   nios2_debug_cmd_sequencer #(.TIMEOUT(T)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .jdo(jdo),
      .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
      .take_action_break_a(ta_ba), .take_action_break_b(ta_bb),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready),
      .monitor_error(monitor_error), .debugack(debugack)
   );

   always #5 clk = ~clk;

   // Expected outputs for the current cycle, written by the model after each rising edge.
   logic        e_rdy, e_vld, e_a, e_b, e_ba, e_bb;
   logic [31:0] e_data;
   logic [1:0]  e_err;
   logic [37:0] e_jdo;
   logic        chk_en = 1'b0;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Single compare point: every output against the model, on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", 64'(cmd_ready), 64'(e_rdy));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_vld));
         chk("rsp_data",  64'(rsp_data),  64'(e_data));
         chk("rsp_err",   64'(rsp_err),   64'(e_err));
         chk("jdo",       64'(jdo),       64'(e_jdo));
         chk("ocimem_a",  64'(ta_a),      64'(e_a));
         chk("ocimem_b",  64'(ta_b),      64'(e_b));
         chk("break_a",   64'(ta_ba),     64'(e_ba));
         chk("break_b",   64'(ta_bb),     64'(e_bb));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic rdy, input logic vld, input logic [31:0] d, input logic [1:0] er,
                          input logic [37:0] j, input logic a, input logic b, input logic ba, input logic bb);
      e_rdy = rdy; e_vld = vld; e_data = d; e_err = er; e_jdo = j;
      e_a = a; e_b = b; e_ba = ba; e_bb = bb;
   endtask

   task automatic junk_inputs();
      cmd_op = 2'($urandom); cmd_addr = 9'($urandom); cmd_wdata = $urandom;
      monitor_ready = 1'($urandom); monitor_error = 1'($urandom);
      MonDReg = $urandom; debugack = 1'($urandom);
   endtask

   // One command from acceptance to return to IDLE.
   // ev_j: index (1-based) of the wait cycle carrying the exit event; 0 = never.
   // ev_kind (memory ops): 0 ready, 1 error, 2 both.  hold: RESP cycles with rsp_ready low.
   task automatic run_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [31:0] wdata,
                          input logic dack0, input int ev_j, input int ev_kind, input int hold,
                          input logic [31:0] mon_val,
                          output int resp_k, output logic [1:0] m_err, output logic [31:0] m_data,
                          output logic [37:0] m_jdo1);
      bit   is_mem, done;
      int   ws, j_exit, k, j;
      logic tgt;
      is_mem = (op == 2'b00 || op == 2'b01);
      tgt    = (op == 2'b10);
      ws     = (op == 2'b01) ? 3 : 2;
      m_jdo1 = '0;
      m_data = '0;
      if (is_mem && !dack0) begin
         resp_k = 1; m_err = 2'b11;
      end else if (is_mem) begin
         if (ev_j >= 2 && ev_j <= T + 1) begin
            j_exit = ev_j;
            m_err  = (ev_kind == 0) ? 2'b00 : 2'b01;
            m_data = (op == 2'b00) ? mon_val : 32'd0;
         end else begin
            j_exit = T + 1; m_err = 2'b10;
         end
         resp_k = ws + j_exit;
         m_jdo1 = ((op == 2'b00) ? (38'd1 << 34) : 38'd0) | 38'(addr);
      end else begin
         if (ev_j >= 1 && ev_j <= T + 1) begin
            j_exit = ev_j; m_err = 2'b00;
         end else begin
            j_exit = T + 1; m_err = 2'b10;
         end
         resp_k = ws + j_exit;
      end

      junk_inputs();
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; debugack = dack0;
      rsp_ready = 1'($urandom);
      set_exp(1'b1, 1'b0, 32'd0, 2'b00, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      k = 0; done = 0;
      while (!done) begin
         cyc();
         k++;
         junk_inputs();
         cmd_valid = 1'($urandom);
         rsp_ready = 1'b0;
         if (k < resp_k) begin
            set_exp(1'b0, 1'b0, 32'd0, 2'b00, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 1 && is_mem)      begin e_a = 1'b1; e_jdo = m_jdo1; end
            if (k == 2 && op == 2'b01) begin e_b = 1'b1; e_jdo = 38'(wdata); end
            if (k == 1 && op == 2'b10) e_ba = 1'b1;
            if (k == 1 && op == 2'b11) e_bb = 1'b1;
            if (k >= ws) begin
               j = k - ws + 1;
               if (is_mem) begin
                  if (j >= 2) begin monitor_ready = 1'b0; monitor_error = 1'b0; end
                  if (j == ev_j) begin
                     monitor_ready = (ev_kind != 1);
                     monitor_error = (ev_kind != 0);
                     MonDReg = mon_val;
                  end
               end else begin
                  debugack = (ev_j >= 1 && j >= ev_j) ? tgt : !tgt;
               end
            end
         end else begin
            set_exp(1'b0, 1'b1, m_data, m_err, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k - resp_k >= hold) begin
               rsp_ready = 1'b1;
               done = 1;
            end
         end
      end
      cyc();
      junk_inputs();
      cmd_valid = 1'b0;
      rsp_ready = 1'($urandom);
      set_exp(1'b1, 1'b0, 32'd0, 2'b00, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         junk_inputs();
         cmd_valid = 1'b0;
         rsp_ready = 1'($urandom);
         set_exp(1'b1, 1'b0, 32'd0, 2'b00, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         cyc();
      end
      cmd_valid = 1'b0;
   endtask

   // Synchronous reset for n cycles; a stray command during reset must be ignored.
   task automatic do_reset(input int n);
      reset = 1'b1;
      cyc();
      set_exp(1'b1, 1'b0, 32'd0, 2'b00, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      for (int i = 1; i < n; i++) begin
         cmd_valid = 1'b1; cmd_op = 2'($urandom);
         cyc();
      end
      reset = 1'b0;
      cmd_valid = 1'b0;
   endtask

   int          rk;
   logic [1:0]  me;
   logic [31:0] md;
   logic [37:0] mj;
   logic [1:0]  rop;

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
      MonDReg = '0; monitor_ready = 1'b0; monitor_error = 1'b0; debugack = 1'b0;
      set_exp(1'b1, 1'b0, 32'd0, 2'b00, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset(2);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("reset_jdo", 64'(jdo), 64'd0);
      idle(2);

      // READ 0x0A5, monitor ready straight after the guard.
      run_cmd(2'b00, 9'h0A5, 32'h0, 1'b1, 2, 0, 0, 32'hDEADBEEF, rk, me, md, mj);
      chk("lit_read_lat", 64'(rk), 64'd4);
      chk("lit_read_jdo", 64'(mj), 64'h04_0000_00A5);
      chk("lit_read_data", 64'(md), 64'hDEADBEEF);
      chk("lit_read_err", 64'(me), 64'd0);

      // WRITE 0x1FF / 0x12345678, back to back.
      run_cmd(2'b01, 9'h1FF, 32'h12345678, 1'b1, 2, 0, 0, 32'h0, rk, me, md, mj);
      chk("lit_write_lat", 64'(rk), 64'd5);
      chk("lit_write_jdo", 64'(mj), 64'h00_0000_01FF);

      // Not halted.
      run_cmd(2'b00, 9'h011, 32'h0, 1'b0, 2, 0, 1, 32'h5555AAAA, rk, me, md, mj);
      chk("lit_nothalt_lat", 64'(rk), 64'd1);
      chk("lit_nothalt_err", 64'(me), 64'd3);

      // monitor_error and monitor_ready together.
      run_cmd(2'b00, 9'h022, 32'h0, 1'b1, 3, 2, 0, 32'hCAFEF00D, rk, me, md, mj);
      chk("lit_both_err", 64'(me), 64'd1);
      chk("lit_both_lat", 64'(rk), 64'd5);

      // BREAK: ack in wait cycle 2, never, and on cycle 8.
      run_cmd(2'b10, 9'h0, 32'h0, 1'b0, 2, 0, 0, 32'h0, rk, me, md, mj);
      chk("lit_break_lat", 64'(rk), 64'd4);
      run_cmd(2'b10, 9'h0, 32'h0, 1'b0, 0, 0, 0, 32'h0, rk, me, md, mj);
      chk("lit_brk_to_lat", 64'(rk), 64'd11);
      chk("lit_brk_to_err", 64'(me), 64'd2);
      run_cmd(2'b10, 9'h0, 32'h0, 1'b0, 8, 0, 0, 32'h0, rk, me, md, mj);
      chk("lit_brk_ack8_lat", 64'(rk), 64'd10);
      chk("lit_brk_ack8_err", 64'(me), 64'd0);

      // Long response stall, then an immediate RESUME.
      run_cmd(2'b00, 9'h100, 32'h0, 1'b1, 4, 0, 20, 32'h0BADBEEF, rk, me, md, mj);
      run_cmd(2'b11, 9'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, rk, me, md, mj);
      chk("lit_resume_lat", 64'(rk), 64'd3);

      // WRITE monitor timeout.
      run_cmd(2'b01, 9'h055, 32'hA5A5A5A5, 1'b1, 0, 0, 0, 32'h0, rk, me, md, mj);
      chk("lit_wr_to_lat", 64'(rk), 64'd12);

      // Reset in the middle of WAIT_MON.
      junk_inputs();
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 9'h033; debugack = 1'b1;
      set_exp(1'b1, 1'b0, 32'd0, 2'b00, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      cmd_valid = 1'b0; monitor_ready = 1'b0; monitor_error = 1'b0;
      set_exp(1'b0, 1'b0, 32'd0, 2'b00, (38'd1 << 34) | 38'h033, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      set_exp(1'b0, 1'b0, 32'd0, 2'b00, 38'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      do_reset(2);
      chk("lit_midreset_rdy", 64'(cmd_ready), 64'd1);
      idle(1);

      // Randomized commands.
      for (int n = 0; n < 80; n++) begin
         rop = 2'($urandom);
         run_cmd(rop, 9'($urandom), $urandom, ($urandom_range(0, 4) != 0),
                 $urandom_range(0, T + 3), $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom, rk, me, md, mj);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      idle(2);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
